// File: rtl/mem_bridge.sv
// mem_bridge: adapts the multicycle core's single-cycle memory strobe to a
// valid/ready memory bus with variable-latency read return.
//
// While an access is outstanding the core is frozen through core_en_o, so the
// control FSM advances only once the instruction or read data is present.
//
// Ports:
//   clk_i, reset_ni            clock, asynchronous active-low reset
//   core_req_i                 core requests an access this cycle
//   core_we_i                  1 = write, 0 = read
//   core_ir_write_i            read result targets instr_o (fetch)
//   core_adr_i, core_wdata_i   byte address and write data from the core
//   core_en_o                  core clock-enable (0 freezes the core)
//   instr_o, data_o            instruction register, read-data register
//   err_o                      sticky error: misaligned address or timeout
//   bus_valid_o/bus_ready_i    request handshake
//   bus_we_o, bus_adr_o,
//   bus_wdata_o                request fields (address word-aligned)
//   bus_rvalid_i, bus_rdata_i  read return
//   dbg_state_o                current FSM state (IDLE=0 REQ=1 WAIT=2 DONE=3)
//
// Handshake: a request transfers on a rising edge where bus_valid_o and
// bus_ready_i are both 1. Once raised, bus_valid_o stays high with bus_we_o,
// bus_adr_o and bus_wdata_o stable until that transfer (or until a timeout
// abort). Read data is a single-cycle bus_rvalid_i pulse, arriving at least
// one cycle after acceptance, with no backpressure from this side.

module mem_bridge #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic              core_ir_write_i,
  input  logic [ADDR_W-1:0] core_adr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_en_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              bus_valid_o,
  input  logic              bus_ready_i,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_adr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Last REQ/WAIT cycle allowed: the counter holds the number of cycles
  // already spent, so this cycle would be number TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   adr_q, adr_d;      // word address; byte offset is never sent
  logic                we_q, we_d;
  logic                ir_q, ir_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tmo;
  logic                abort;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    ir_d    = ir_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    abort   = 1'b0;
    tmo     = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          adr_d   = core_adr_i[ADDR_W-1:2];
          we_d    = core_we_i;
          ir_d    = core_ir_write_i;
          wdata_d = core_wdata_i;
          cnt_d   = '0;
          if (core_adr_i[1:0] != 2'b00) begin
            // Misaligned: never reaches the bus; reads return the abort value.
            err_d   = 1'b1;
            state_d = DONE;
            if (!core_we_i) begin
              if (core_ir_write_i) instr_d = NOP_INSTR;
              else                 data_d  = '0;
            end
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A write finishes on acceptance and beats a simultaneous timeout.
        // A read accepted in its last allowed cycle has not completed yet,
        // so it aborts.
        if (bus_ready_i && we_q) state_d = DONE;
        else if (tmo)            abort   = 1'b1;
        else if (bus_ready_i)    state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus_rvalid_i) begin
          if (ir_q) instr_d = bus_rdata_i;
          else      data_d  = bus_rdata_i;
          state_d = DONE;
        end else if (tmo) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        // core_req_i is still held by the frozen core here; ignore it.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      err_d   = 1'b1;
      state_d = DONE;
      if (!we_q) begin
        if (ir_q) instr_d = NOP_INSTR;
        else      data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      ir_q    <= 1'b0;
      wdata_q <= '0;
      instr_q <= NOP_INSTR;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      ir_q    <= ir_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The core runs when nothing is pending: idle with no request, or the
  // single DONE cycle that lets the control FSM consume the result.
  assign core_en_o   = ((state_q == IDLE) && !core_req_i) || (state_q == DONE);
  assign bus_valid_o = (state_q == REQ);
  assign bus_we_o    = we_q;
  assign bus_adr_o   = {adr_q, 2'b00};
  assign bus_wdata_o = wdata_q;
  assign instr_o     = instr_q;
  assign data_o      = data_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_WAIT = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        core_req_i = 1'b0, core_we_i = 1'b0, core_ir_write_i = 1'b0;
  logic [31:0] core_adr_i = '0, core_wdata_i = '0;
  logic        bus_ready_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  // dut_a: default TIMEOUT; dut_b: TIMEOUT = 4. Both see the same stimulus.
  logic        core_en_a, err_a, bus_valid_a, bus_we_a;
  logic [31:0] instr_a, data_a, bus_adr_a, bus_wdata_a;
  logic [1:0]  state_a;
  logic        core_en_b, err_b, bus_valid_b, bus_we_b;
  logic [31:0] instr_b, data_b, bus_adr_b, bus_wdata_b;
  logic [1:0]  state_b;

  mem_bridge dut_a (
    .clk_i(clk_i), .reset_ni(reset_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_ir_write_i(core_ir_write_i), .core_adr_i(core_adr_i), .core_wdata_i(core_wdata_i),
    .core_en_o(core_en_a), .instr_o(instr_a), .data_o(data_a), .err_o(err_a),
    .bus_valid_o(bus_valid_a), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_a),
    .bus_adr_o(bus_adr_a), .bus_wdata_o(bus_wdata_a), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .dbg_state_o(state_a)
  );

  mem_bridge #(.TIMEOUT(4)) dut_b (
    .clk_i(clk_i), .reset_ni(reset_ni), .core_req_i(core_req_i), .core_we_i(core_we_i),
    .core_ir_write_i(core_ir_write_i), .core_adr_i(core_adr_i), .core_wdata_i(core_wdata_i),
    .core_en_o(core_en_b), .instr_o(instr_b), .data_o(data_b), .err_o(err_b),
    .bus_valid_o(bus_valid_b), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_b),
    .bus_adr_o(bus_adr_b), .bus_wdata_o(bus_wdata_b), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .dbg_state_o(state_b)
  );

  logic        use_to = 1'b0;
  logic        mon_core_en, mon_err, mon_bus_valid, mon_bus_we;
  logic [31:0] mon_instr, mon_data, mon_bus_adr, mon_bus_wdata;
  logic [1:0]  mon_state;

  always_comb begin
    mon_core_en   = use_to ? core_en_b   : core_en_a;
    mon_err       = use_to ? err_b       : err_a;
    mon_bus_valid = use_to ? bus_valid_b : bus_valid_a;
    mon_bus_we    = use_to ? bus_we_b    : bus_we_a;
    mon_instr     = use_to ? instr_b     : instr_a;
    mon_data      = use_to ? data_b      : data_a;
    mon_bus_adr   = use_to ? bus_adr_b   : bus_adr_a;
    mon_bus_wdata = use_to ? bus_wdata_b : bus_wdata_a;
    mon_state     = use_to ? state_b     : state_a;
  end

  // ---------------- scoreboard ----------------
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_i);
    reset_ni = 1'b0;
    core_req_i = 1'b0; core_we_i = 1'b0; core_ir_write_i = 1'b0;
    core_adr_i = '0; core_wdata_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    exp_q.delete();
  endtask

  // Runs one core access plus a bus responder. Entered and left at a negedge
  // in IDLE. Pushes the expected target-register value of every read.
  task automatic drive_access(input logic we, input logic ir, input logic [31:0] adr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ready_wait, input int rvalid_wait, input bit give_rvalid,
                              output int en_low, output int valid_cycles, output int first_valid,
                              output bit stable_ok, output bit done, output bit idle_after);
    bit acc_pend, accepted, pushed;
    int wait_cnt;
    en_low = 0; valid_cycles = 0; first_valid = -1; stable_ok = 1'b1; done = 1'b0;
    idle_after = 1'b0; acc_pend = 1'b0; accepted = 1'b0; pushed = 1'b0; wait_cnt = 0;
    core_req_i = 1'b1; core_we_i = we; core_ir_write_i = ir;
    core_adr_i = adr; core_wdata_i = wdata;
    #1;
    if (!mon_core_en) en_low++;
    for (int c = 1; c < 64 && !done; c++) begin
      @(negedge clk_i);
      if (acc_pend) accepted = 1'b1;
      acc_pend = 1'b0;
      bus_rvalid_i = 1'b0;
      if (mon_core_en) begin
        done = 1'b1;
      end else begin
        en_low++;
        if (mon_bus_valid) begin
          valid_cycles++;
          if (first_valid < 0) first_valid = c;
          if (mon_bus_adr !== {adr[31:2], 2'b00} || mon_bus_we !== we ||
              (we && mon_bus_wdata !== wdata)) stable_ok = 1'b0;
          bus_ready_i = (valid_cycles > ready_wait);
          acc_pend = bus_ready_i;
          // Stray read data while the request is still pending must be ignored.
          if (!we && !bus_ready_i) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdata ^ 32'hBAD0_0000;
          end
        end else begin
          bus_ready_i = 1'b0;
        end
        if (accepted && !we && give_rvalid && !pushed) begin
          if (wait_cnt == rvalid_wait) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdata;
            exp_q.push_back(rdata);
            pushed = 1'b1;
          end
          wait_cnt++;
        end
      end
    end
    if (!we && !pushed) exp_q.push_back(ir ? NOP : 32'h0);
    core_req_i = 1'b0; bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
    @(negedge clk_i);
    idle_after = (mon_state == ST_IDLE) && mon_core_en;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    use_to = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b0; core_req_i = 1'b0;
    #1;
    checks++; if (mon_core_en !== 1'b1) begin errors++; $display("FAIL rst_core_en: got %0h expected 1", mon_core_en); end
    checks++; if (mon_bus_valid !== 1'b0) begin errors++; $display("FAIL rst_bus_valid: got %0h expected 0", mon_bus_valid); end
    checks++; if (mon_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h expected %h", mon_instr, NOP); end
    checks++; if (mon_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", mon_data); end
    checks++; if (mon_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %0h expected 0", mon_err); end
    checks++; if (mon_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", mon_state); end
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_fetch();
    int en_low, vc, fv; bit st, dn, ia; logic [31:0] exp;
    use_to = 1'b0;
    do_reset();
    drive_access(1'b0, 1'b1, 32'h100, 32'h0, 32'h00500093, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL fetch_done: got %0d expected 1", dn); end
    checks++; if (en_low !== 3) begin errors++; $display("FAIL fetch_en_low: got %0d expected 3", en_low); end
    checks++; if (fv !== 1 || vc !== 1) begin errors++; $display("FAIL fetch_valid: got first=%0d cycles=%0d expected 1/1", fv, vc); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL fetch_bus_fields: got %0d expected 1", st); end
    checks++; if (mon_instr !== exp) begin errors++; $display("FAIL fetch_instr: got %h expected %h", mon_instr, exp); end
    checks++; if (mon_data !== 32'h0) begin errors++; $display("FAIL fetch_data: got %h expected 0", mon_data); end
    checks++; if (ia !== 1'b1) begin errors++; $display("FAIL fetch_done_one_cycle: got %0d expected 1", ia); end
  endtask

  task automatic test_write_backpressure();
    int en_low, vc, fv; bit st, dn, ia;
    use_to = 1'b0;
    do_reset();
    drive_access(1'b1, 1'b0, 32'h204, 32'hDEADBEEF, 32'h0, 4, 0, 1'b0, en_low, vc, fv, st, dn, ia);
    checks++; if (vc !== 5) begin errors++; $display("FAIL wr_valid_cycles: got %0d expected 5", vc); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL wr_fields_stable: got %0d expected 1", st); end
    checks++; if (en_low !== 6 || dn !== 1'b1) begin errors++; $display("FAIL wr_en_low: got %0d done=%0d expected 6 done=1", en_low, dn); end
    checks++; if (mon_instr !== NOP || mon_data !== 32'h0) begin errors++; $display("FAIL wr_regs: got %h/%h expected %h/0", mon_instr, mon_data, NOP); end
    checks++; if (mon_err !== 1'b0) begin errors++; $display("FAIL wr_err: got %0h expected 0", mon_err); end
    drive_access(1'b1, 1'b0, 32'h208, 32'h01234567, 32'h0, 0, 0, 1'b0, en_low, vc, fv, st, dn, ia);
    checks++; if (en_low !== 2 || vc !== 1 || st !== 1'b1) begin errors++; $display("FAIL wr_zero_wait: got en_low=%0d valid=%0d stable=%0d expected 2/1/1", en_low, vc, st); end
  endtask

  task automatic test_read_backpressure();
    int en_low, vc, fv; bit st, dn, ia; logic [31:0] exp;
    use_to = 1'b0;
    do_reset();
    drive_access(1'b0, 1'b0, 32'h3000, 32'h0, 32'hCAFEF00D, 2, 1, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (vc !== 3 || st !== 1'b1) begin errors++; $display("FAIL rd_bp_valid: got %0d stable=%0d expected 3/1", vc, st); end
    checks++; if (en_low !== 6) begin errors++; $display("FAIL rd_bp_en_low: got %0d expected 6", en_low); end
    checks++; if (mon_data !== exp) begin errors++; $display("FAIL rd_bp_data: got %h expected %h", mon_data, exp); end
    checks++; if (mon_instr !== NOP) begin errors++; $display("FAIL rd_bp_instr_hold: got %h expected %h", mon_instr, NOP); end
  endtask

  task automatic test_misaligned();
    int en_low, vc, fv; bit st, dn, ia; logic [31:0] exp, ins;
    use_to = 1'b0;
    do_reset();
    drive_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h12345678, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_data !== exp) begin errors++; $display("FAIL mis_setup_data: got %h expected %h", mon_data, exp); end
    drive_access(1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (vc !== 0) begin errors++; $display("FAIL mis_no_bus: got %0d valid cycles expected 0", vc); end
    checks++; if (en_low !== 1 || dn !== 1'b1 || ia !== 1'b1) begin errors++; $display("FAIL mis_en: got en_low=%0d done=%0d idle=%0d expected 1/1/1", en_low, dn, ia); end
    checks++; if (mon_err !== 1'b1) begin errors++; $display("FAIL mis_err: got %0h expected 1", mon_err); end
    checks++; if (mon_data !== exp) begin errors++; $display("FAIL mis_data: got %h expected %h", mon_data, exp); end
    drive_access(1'b0, 1'b1, 32'h80, 32'h0, 32'h00A00113, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    ins = exp_q.pop_front();
    checks++; if (mon_instr !== ins) begin errors++; $display("FAIL mis_fetch_ok: got %h expected %h", mon_instr, ins); end
    drive_access(1'b0, 1'b1, 32'h81, 32'h0, 32'h0, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_instr !== exp || vc !== 0) begin errors++; $display("FAIL mis_fetch_instr: got %h valid=%0d expected %h valid=0", mon_instr, vc, exp); end
    drive_access(1'b1, 1'b0, 32'h203, 32'hFFFF0000, 32'h0, 0, 0, 1'b0, en_low, vc, fv, st, dn, ia);
    checks++; if (vc !== 0 || mon_instr !== NOP || mon_data !== 32'h0) begin errors++; $display("FAIL mis_write: got valid=%0d %h/%h expected 0 %h/0", vc, mon_instr, mon_data, NOP); end
    drive_access(1'b0, 1'b0, 32'h44, 32'h0, 32'h0F0F0F0F, 0, 2, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_data !== exp || mon_err !== 1'b1) begin errors++; $display("FAIL mis_after: got %h err=%0h expected %h err=1", mon_data, mon_err, exp); end
  endtask

  task automatic test_timeout();
    int en_low, vc, fv; bit st, dn, ia; logic [31:0] exp;
    use_to = 1'b1;
    do_reset();
    // rvalid in the fourth REQ+WAIT cycle: completion beats the timeout.
    drive_access(1'b0, 1'b0, 32'h500, 32'h0, 32'hA5A50001, 0, 2, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_err !== 1'b0) begin errors++; $display("FAIL to_edge_err: got %0h expected 0", mon_err); end
    checks++; if (mon_data !== exp || en_low !== 5) begin errors++; $display("FAIL to_edge_data: got %h en_low=%0d expected %h 5", mon_data, en_low, exp); end
    // One cycle later: aborted.
    drive_access(1'b0, 1'b0, 32'h504, 32'h0, 32'h0, 0, 3, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_err !== 1'b1) begin errors++; $display("FAIL to_err: got %0h expected 1", mon_err); end
    checks++; if (mon_data !== exp) begin errors++; $display("FAIL to_data: got %h expected %h", mon_data, exp); end
    checks++; if (en_low !== 5 || dn !== 1'b1 || ia !== 1'b1) begin errors++; $display("FAIL to_en: got en_low=%0d done=%0d idle=%0d expected 5/1/1", en_low, dn, ia); end
    // Never accepted: valid drops after the fourth cycle.
    drive_access(1'b1, 1'b0, 32'h508, 32'h11112222, 32'h0, 100, 0, 1'b0, en_low, vc, fv, st, dn, ia);
    checks++; if (vc !== 4 || en_low !== 5 || dn !== 1'b1) begin errors++; $display("FAIL to_req: got valid=%0d en_low=%0d done=%0d expected 4/5/1", vc, en_low, dn); end
    drive_access(1'b0, 1'b1, 32'h50C, 32'h0, 32'h0BADF00D, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_instr !== exp || mon_err !== 1'b1) begin errors++; $display("FAIL to_recover: got %h err=%0h expected %h err=1", mon_instr, mon_err, exp); end
    use_to = 1'b0;
  endtask

  task automatic test_reset_mid();
    int en_low, vc, fv; bit st, dn, ia; logic [31:0] exp;
    use_to = 1'b0;
    do_reset();
    drive_access(1'b0, 1'b0, 32'h2, 32'h0, 32'h0, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    drive_access(1'b0, 1'b1, 32'h10, 32'h0, 32'h11111111, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    exp = exp_q.pop_front();
    checks++; if (mon_instr !== exp || mon_err !== 1'b1) begin errors++; $display("FAIL rm_setup: got %h err=%0h expected %h err=1", mon_instr, mon_err, exp); end
    core_req_i = 1'b1; core_we_i = 1'b0; core_ir_write_i = 1'b1; core_adr_i = 32'h20;
    @(negedge clk_i);
    bus_ready_i = 1'b1;
    @(negedge clk_i);
    bus_ready_i = 1'b0;
    checks++; if (mon_state !== ST_WAIT) begin errors++; $display("FAIL rm_in_wait: got %0d expected 2", mon_state); end
    reset_ni = 1'b0;
    #1;
    checks++; if (mon_bus_valid !== 1'b0 || mon_state !== ST_IDLE) begin errors++; $display("FAIL rm_wait_state: got valid=%0h state=%0d expected 0/0", mon_bus_valid, mon_state); end
    checks++; if (mon_instr !== NOP || mon_err !== 1'b0) begin errors++; $display("FAIL rm_wait_regs: got %h err=%0h expected %h err=0", mon_instr, mon_err, NOP); end
    @(negedge clk_i);
    reset_ni = 1'b1; core_req_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h77777777;
    @(negedge clk_i);
    bus_rvalid_i = 1'b0;
    checks++; if (mon_state !== ST_IDLE || mon_instr !== NOP || mon_data !== 32'h0 || mon_core_en !== 1'b1) begin
      errors++; $display("FAIL rm_late_rvalid: got state=%0d instr=%h data=%h en=%0h expected 0/%h/0/1", mon_state, mon_instr, mon_data, mon_core_en, NOP);
    end
    core_req_i = 1'b1; core_ir_write_i = 1'b0; core_adr_i = 32'h24;
    @(negedge clk_i);
    checks++; if (mon_bus_valid !== 1'b1) begin errors++; $display("FAIL rm_req_valid: got %0h expected 1", mon_bus_valid); end
    reset_ni = 1'b0; core_req_i = 1'b0;
    #1;
    checks++; if (mon_bus_valid !== 1'b0) begin errors++; $display("FAIL rm_req_drop: got %0h expected 0", mon_bus_valid); end
    @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic test_back_to_back();
    int en_low, vc, fv; bit st, dn, ia; logic [31:0] e_ins, e_dat;
    use_to = 1'b0;
    do_reset();
    drive_access(1'b0, 1'b1, 32'h40, 32'h0, 32'h00100093, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    e_ins = exp_q.pop_front();
    // Entered one cycle after the first DONE, so cycle 1 here is DONE + 2.
    drive_access(1'b0, 1'b0, 32'h44, 32'h0, 32'h5A5A5A5A, 0, 0, 1'b1, en_low, vc, fv, st, dn, ia);
    e_dat = exp_q.pop_front();
    checks++; if (fv !== 1) begin errors++; $display("FAIL b2b_valid_rise: got cycle %0d expected 1", fv); end
    checks++; if (mon_instr !== e_ins) begin errors++; $display("FAIL b2b_instr: got %h expected %h", mon_instr, e_ins); end
    checks++; if (mon_data !== e_dat) begin errors++; $display("FAIL b2b_data: got %h expected %h", mon_data, e_dat); end
    checks++; if (mon_err !== 1'b0 || en_low !== 3) begin errors++; $display("FAIL b2b_misc: got err=%0h en_low=%0d expected 0/3", mon_err, en_low); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_fetch();
    test_write_backpressure();
    test_read_backpressure();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
